// File: rtl/counter_seq_ctrl_pkg.sv
// Shared state and mode encodings for the counter_seq_ctrl timer block.
package counter_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_seq_ctrl_seq_up_counter.sv
// N-bit synchronous up-counter built from a T flip-flop chain, with
// enable and synchronous clear.
module seq_up_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;
  logic [N-1:0] w_t;

  // Bit i toggles when enabled and every lower bit is one.
  assign w_t[0] = i_en;
  for (genvar i = 1; i < N; i++) begin : g_tchain
    assign w_t[i] = i_en & (&r_q[i-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset || i_clr) r_q <= '0;
    else                r_q <= r_q ^ w_t;
  end

  assign o_q = r_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Programmable timer controller around seq_up_counter: config handshake,
// start/stop sequencing, terminal-count strobe. Prescaler: COUNTER_SEQ_CTRL_PRESCALE_EN.
//
// state    | meaning
// ST_IDLE  | stopped, config accepted
// ST_RUN   | counting toward stored limit
// ST_PAUSE | stopped mid-run, count held
// ST_DONE  | one-shot finished, count holds limit, done high
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int N = 4
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
  , parameter int PW = 4
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_limit,
  input  logic          cfg_periodic,
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
  input  logic [PW-1:0] cfg_div,
`endif
  input  logic          start,
  input  logic          stop,
  output logic [N-1:0]  count,
  output logic          busy,
  output logic          tc_pulse,
  output logic          done
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_limit;
  logic         r_mode;
  logic         r_tc;
  logic         w_tc_nxt;
  logic         w_cnt_clr;
  logic         w_cnt_en;
  logic         w_pre_clr;
  logic         w_tick;
  logic         w_xfer;
  logic [N-1:0] w_count;

  assign cfg_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_xfer    = cfg_valid & cfg_ready;

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
  logic [PW-1:0] r_div;
  logic [PW-1:0] r_pre;

  assign w_tick = (r_pre == r_div);

  always_ff @(posedge clk) begin
    if (reset)       r_div <= '0;
    else if (w_xfer) r_div <= cfg_div;
  end

  // Free-runs only while RUN keeps going; restarted on start and resume.
  always_ff @(posedge clk) begin
    if (reset || w_pre_clr)               r_pre <= '0;
    else if (r_state == ST_RUN && !stop)  r_pre <= w_tick ? '0 : r_pre + 1'b1;
  end
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_limit <= '0;
      r_mode  <= MODE_ONESHOT;
    end else if (w_xfer) begin
      r_limit <= cfg_limit;
      r_mode  <= cfg_periodic;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tc_nxt    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_pre_clr   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          w_state_nxt = ST_RUN;
          w_cnt_clr   = 1'b1;
          w_pre_clr   = 1'b1;
        end else if (w_xfer) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_tick) begin
          if (w_count == r_limit) begin
            w_tc_nxt = 1'b1;
            if (r_mode == MODE_PERIODIC) w_cnt_clr   = 1'b1;
            else                         w_state_nxt = ST_DONE;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_cnt_clr   = 1'b1;
        end else if (start) begin
          w_state_nxt = ST_RUN;
          w_pre_clr   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  seq_up_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_q   (w_count)
  );

  assign count    = w_count;
  assign busy     = (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign tc_pulse = r_tc;
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl (N=4).
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_limit = '0;
  logic       cfg_periodic = 1'b0;
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
  logic [3:0] cfg_div = '0;
`endif
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       tc_pulse;
  logic       done;

  int total = 0;
  int bad   = 0;
  int tcs;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.N(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_limit    (cfg_limit),
    .cfg_periodic (cfg_periodic),
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
    .cfg_div      (cfg_div),
`endif
    .start        (start),
    .stop         (stop),
    .count        (count),
    .busy         (busy),
    .tc_pulse     (tc_pulse),
    .done         (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_start(input logic [3:0] lim, input logic per);
    cfg_valid = 1'b1; cfg_limit = lim; cfg_periodic = per; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    // reset
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_tc", 32'(tc_pulse), 0);

    // one-shot limit 3
    cfg_start(4'd3, 1'b0);
    chk("os3_c0", 32'(count), 0);
    chk("os3_busy", 32'(busy), 1);
    chk("os3_ready", 32'(cfg_ready), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("os3_cnt", 32'(count), 32'(k));
      chk("os3_tc_lo", 32'(tc_pulse), 0);
      chk("os3_done_lo", 32'(done), 0);
    end
    tick();
    chk("os3_tc", 32'(tc_pulse), 1);
    chk("os3_done", 32'(done), 1);
    chk("os3_hold", 32'(count), 3);
    chk("os3_idle_busy", 32'(busy), 0);
    chk("os3_ready_back", 32'(cfg_ready), 1);
    tick();
    chk("os3_tc_once", 32'(tc_pulse), 0);
    chk("os3_done_lvl", 32'(done), 1);
    chk("os3_hold2", 32'(count), 3);

    // periodic limit 2, started straight from DONE
    cfg_start(4'd2, 1'b1);
    chk("p2_c0", 32'(count), 0);
    chk("p2_done_clr", 32'(done), 0);
    tcs = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("p2_cnt", 32'(count), 32'(k % 3));
      chk("p2_tc", 32'(tc_pulse), (k % 3 == 0) ? 32'd1 : 32'd0);
      chk("p2_ready", 32'(cfg_ready), 0);
      if (tc_pulse) tcs++;
    end
    chk("p2_tc_total", 32'(tcs), 3);
    stop = 1'b1; tick(); tick(); stop = 1'b0;
    chk("p2_abort_cnt", 32'(count), 0);
    chk("p2_abort_busy", 32'(busy), 0);

    // periodic limit 15: pause, resume, ignored start, abort
    cfg_start(4'd15, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    chk("p15_c5", 32'(count), 5);
    stop = 1'b1; tick(); stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("p15_pause_hold", 32'(count), 5);
      chk("p15_pause_busy", 32'(busy), 1);
      chk("p15_pause_tc", 32'(tc_pulse), 0);
      if (k < 3) tick();
    end
    start = 1'b1; tick();
    chk("p15_resume", 32'(count), 5);
    tick();
    chk("p15_run_start_ign", 32'(count), 6);
    start = 1'b0; tick();
    chk("p15_c7", 32'(count), 7);
    stop = 1'b1; tick();
    chk("p15_pause7", 32'(count), 7);
    start = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("p15_both_cnt", 32'(count), 0);
    chk("p15_both_busy", 32'(busy), 0);
    chk("p15_both_ready", 32'(cfg_ready), 1);

    // wrap at all-ones
    cfg_start(4'd15, 1'b1);
    for (int k = 0; k < 15; k++) tick();
    chk("wrap_c15", 32'(count), 15);
    tick();
    chk("wrap_c0", 32'(count), 0);
    chk("wrap_tc", 32'(tc_pulse), 1);
    stop = 1'b1; tick(); tick(); stop = 1'b0;

    // one-shot limit 0, then config transfer in DONE
    cfg_start(4'd0, 1'b0);
    chk("os0_busy", 32'(busy), 1);
    chk("os0_done_lo", 32'(done), 0);
    tick();
    chk("os0_done", 32'(done), 1);
    chk("os0_tc", 32'(tc_pulse), 1);
    cfg_valid = 1'b1; cfg_limit = 4'd15; cfg_periodic = 1'b0;
    tick();
    cfg_valid = 1'b0;
    chk("xfer_done_clr", 32'(done), 0);
    chk("xfer_idle_busy", 32'(busy), 0);

    // reset mid-run at count 7
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("rmid_c7", 32'(count), 7);
    reset = 1'b1; tick();
    chk("rmid_cnt", 32'(count), 0);
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_tc", 32'(tc_pulse), 0);
    reset = 1'b0; tick();
    chk("rmid_tc2", 32'(tc_pulse), 0);
    chk("rmid_ready", 32'(cfg_ready), 1);

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
    // prescaler div 2, limit 1 periodic
    cfg_div = 4'd2;
    cfg_start(4'd1, 1'b1);
    cfg_div = 4'd0;
    chk("pre_c0", 32'(count), 0);
    tcs = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("pre_cnt", 32'(count), 32'((k / 3) % 2));
      chk("pre_tc", 32'(tc_pulse), (k % 6 == 0) ? 32'd1 : 32'd0);
      if (tc_pulse) tcs++;
    end
    chk("pre_tc_total", 32'(tcs), 2);
    stop = 1'b1; tick(); tick(); stop = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
